// File: rtl/multi_mode_alu.sv
// Registered four-mode 4-bit ALU: add, multiply, BCD conversion of A, and zero.
// One-cycle latency; out_valid follows in_valid and Y holds its value on idle cycles.
module multi_mode_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] Mode,
    output logic [7:0] Y,
    output logic       out_valid
);

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_MUL  = 2'b01,
        MODE_BCD  = 2'b10,
        MODE_ZERO = 2'b11
    } mode_t;

    mode_t      mode;
    logic [7:0] result;
    logic       tens;
    logic [3:0] units;

    assign mode = mode_t'(Mode);

    // A is at most 15, so the tens digit is a single compare and units a single subtract
    assign tens  = (A >= 4'd10);
    assign units = tens ? (A - 4'd10) : A;

    always_comb begin
        result = '0;
        case (mode)
            MODE_ADD:  result = {4'b0, A} + {4'b0, B};
            MODE_MUL:  result = {4'b0, A} * {4'b0, B};
            MODE_BCD:  result = {3'b0, tens, units};
            MODE_ZERO: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                Y <= result;
        end
    end

endmodule

// File: tb/tb_multi_mode_alu.sv
// Self-checking bench for multi_mode_alu: directed spec cases, back-to-back stream,
// asynchronous mid-cycle reset, and randomized traffic against an arithmetic model.
module tb_multi_mode_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] Mode;
    logic [7:0] Y;
    logic       out_valid;

    int tests;
    int failures;

    logic [7:0] exp_y;
    logic       exp_v;

    multi_mode_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Mode      (Mode),
        .Y         (Y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_result(input int m, input int a, input int b);
        int r;
        case (m)
            0:       r = a + b;
            1:       r = a * b;
            2:       r = (a / 10) * 16 + (a % 10);
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive at the falling edge, update the model at the rising edge, sample 1 time unit later.
    task automatic step(input logic iv, input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                        input string tag);
        @(negedge clk);
        in_valid = iv;
        Mode     = m;
        A        = a;
        B        = b;
        @(posedge clk);
        if (rst_n) begin
            if (iv)
                exp_y = ref_result(int'(m), int'(a), int'(b));
            exp_v = iv;
        end
        #1;
        check({tag, ".y"}, Y, exp_y);
        check({tag, ".valid"}, {7'b0, out_valid}, {7'b0, exp_v});
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        exp_y    = '0;
        exp_v    = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        Mode     = 2'b01;
        A        = 4'hF;
        B        = 4'hF;

        // Reset held with live inputs across several edges
        repeat (3) @(posedge clk);
        #1;
        check("reset.y", Y, 8'h00);
        check("reset.valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with literal expectations
        step(1'b1, 2'b00, 4'd5, 4'd3, "add_5_3");     check("add_5_3.lit", Y, 8'd8);
        step(1'b1, 2'b00, 4'd9, 4'd6, "add_9_6");     check("add_9_6.lit", Y, 8'd15);
        step(1'b1, 2'b00, 4'd15, 4'd15, "add_max");   check("add_max.lit", Y, 8'h1E);
        step(1'b1, 2'b01, 4'd4, 4'd3, "mul_4_3");     check("mul_4_3.lit", Y, 8'd12);
        step(1'b1, 2'b01, 4'd7, 4'd2, "mul_7_2");     check("mul_7_2.lit", Y, 8'd14);
        step(1'b1, 2'b01, 4'd15, 4'd15, "mul_max");   check("mul_max.lit", Y, 8'hE1);
        step(1'b1, 2'b10, 4'd8, 4'd0, "bcd_8");       check("bcd_8.lit", Y, 8'h08);
        step(1'b1, 2'b10, 4'd15, 4'd0, "bcd_15");     check("bcd_15.lit", Y, 8'h15);
        step(1'b1, 2'b10, 4'd10, 4'd9, "bcd_10_b9");  check("bcd_10_b9.lit", Y, 8'h10);
        step(1'b1, 2'b01, 4'd9, 4'd9, "mul_pre");     check("mul_pre.lit", Y, 8'd81);
        step(1'b1, 2'b11, 4'd0, 4'd0, "zero");        check("zero.lit", Y, 8'h00);
        check("zero.valid.lit", {7'b0, out_valid}, 8'h01);
        step(1'b0, 2'b00, 4'd5, 4'd5, "idle");        check("idle.hold.lit", Y, 8'h00);
        check("idle.valid.lit", {7'b0, out_valid}, 8'h00);
        step(1'b1, 2'b01, 4'd6, 4'd7, "mul_6_7");
        step(1'b0, 2'b00, 4'd1, 4'd1, "idle_hold");   check("idle_hold.lit", Y, 8'd42);

        // Back-to-back stream with no bubbles
        step(1'b1, 2'b00, 4'd5, 4'd3, "b2b_add");     check("b2b_add.lit", Y, 8'd8);
        step(1'b1, 2'b01, 4'd7, 4'd2, "b2b_mul");     check("b2b_mul.lit", Y, 8'd14);
        step(1'b1, 2'b10, 4'd15, 4'd0, "b2b_bcd");    check("b2b_bcd.lit", Y, 8'h15);
        step(1'b1, 2'b11, 4'd3, 4'd4, "b2b_zero");    check("b2b_zero.lit", Y, 8'h00);

        // Asynchronous reset between clock edges
        step(1'b1, 2'b01, 4'd13, 4'd11, "pre_rst");   check("pre_rst.lit", Y, 8'd143);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.y", Y, 8'h00);
        check("async_rst.valid", {7'b0, out_valid}, 8'h00);
        exp_y = '0;
        exp_v = 1'b0;
        step(1'b1, 2'b00, 4'd7, 4'd7, "rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 4'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_mode_alu.md
# multi_mode_alu

Registered 4-bit, four-mode arithmetic unit producing an 8-bit result: unsigned add, unsigned multiply, binary-to-BCD conversion of A, and a zero/idle mode. It sits in the datapath as a single-cycle-latency functional unit. Operands and mode are sampled on a clock edge, and the result is presented from an output register one cycle later, together with a valid flag.

## Interface
- No parameters. Widths are fixed at 4-bit operands and an 8-bit result.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies A, B and Mode on this edge
- A  input  4  operand A, unsigned
- B  input  4  operand B, unsigned
- Mode  input  2  operation select
- Y  output  8  registered result
- out_valid  output  1  Y holds the result of a qualified operation

## Operation
- Mode 2'b00, ADD:
  - Y = {4'b0, A} + {4'b0, B}.
  - Range 0..30; the carry lands in Y[4]; no overflow is possible.
- Mode 2'b01, MUL:
  - Y = A * B, unsigned.
  - Range 0..225; always fits in 8 bits; no truncation.
- Mode 2'b10, BCD:
  - Y[7:4] = A / 10 (tens digit, 0 or 1).
  - Y[3:0] = A % 10 (units digit).
  - B is ignored.
  - Examples: A=8 gives 8'h08; A=15 gives 8'h15.
- Mode 2'b11, ZERO: Y = 8'h00. A and B are ignored.
- Result selection is purely a function of the sampled A, B and Mode. No state is carried between operations.
- The operation is computed combinationally from the inputs and captured into the Y register on the clock edge.
- The implementation must cover every mode value. X on Mode is not a legal input.

## Timing
- Reset, asynchronous on rst_n low:
  - Y = 8'h00 and out_valid = 0, immediately and without waiting for clk.
  - Both outputs hold these values while rst_n stays low.
- Reset release: the first active edge is the first rising clk edge with rst_n high.
- Latency: inputs sampled at rising edge N with in_valid=1 give Y = result and out_valid=1 after edge N.
- in_valid=0 at an edge: out_valid goes to 0 after that edge, and Y holds its previous value.
- Throughput: one operation per cycle. Back-to-back qualified inputs produce back-to-back results with no bubbles.
- Mode changes between cycles take effect at the next sampling edge. There is no pipeline flush and no hazard.
- Reset asserted mid-stream:
  - Any in-flight result is discarded.
  - Outputs return to their reset values at once.
- No handshake back-pressure exists. The consumer must take Y in the cycle out_valid is high.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs -> Y=8'h00 and out_valid=0. Assert rst_n mid-operation, asynchronously between clk edges -> outputs clear immediately.
- ADD: Mode=00 with A=5,B=3 -> Y=8 next cycle. Mode=00 with A=9,B=6 -> Y=15. Mode=00 with A=15,B=15 -> Y=30 (8'h1E).
- MUL: Mode=01 with A=4,B=3 -> Y=12. Mode=01 with A=7,B=2 -> Y=14. Mode=01 with A=15,B=15 -> Y=225 (8'hE1).
- BCD: Mode=10 with A=8,B=0 -> Y=8'h08. Mode=10 with A=15,B=0 -> Y=8'h15. Mode=10 with A=10,B=9 -> Y=8'h10, since B is ignored.
- ZERO and valid gating:
  - Mode=11 with A=0,B=0 -> Y=8'h00 and out_valid=1.
  - Then drop in_valid to 0 -> out_valid=0 and Y holds 8'h00.
- Back-to-back: stream ADD(5,3), MUL(7,2), BCD(15), ZERO on four consecutive edges -> Y = 8, 14, 8'h15, 0 on four consecutive cycles with out_valid held at 1.
